// File: rtl/cordic_sched_pkg.sv
// Shared definitions for the iterative CORDIC sequencer.
//   state_e      : sequencer state encoding
//   MMODE_*      : coordinate-system selector strings, same encoding as the rotation stages
//   REP_IDX      : hyperbolic shift indices that are executed twice
//   n_exec()     : number of micro-rotations a job performs
package cordic_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_ISSUE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   localparam string MMODE_CIRC = "1";
   localparam string MMODE_LIN  = "0";
   localparam string MMODE_HYP  = "-1";

   localparam int N_REP = 3;
   localparam int REP_IDX [N_REP] = '{4, 13, 40};

   // Micro-rotations per job: one per index, plus one extra for every
   // hyperbolic repeat index that falls inside the sequence.
   function automatic int n_exec(input bit hyp, input int iters);
      int n;
      n = iters;
      if (hyp) begin
         for (int k = 0; k < N_REP; k++) begin
            if (REP_IDX[k] <= iters) n++;
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/cordic_iter_index.sv
// Shift-index generator for the CORDIC sequencer.
//   clock, rst  : clock and synchronous active-high reset
//   init_i      : load the first index of the sequence
//   advance_i   : one micro-rotation has been written back
//   index_o     : current shift index
//   last_o      : the current micro-rotation is the final one of the job
module cordic_iter_index
   import cordic_sched_pkg::*;
#(
   parameter string MMODE = "0",
   parameter int    PSIZE = 5,
   parameter int    ITERS = 16
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             init_i,
   input  logic             advance_i,
   output logic [PSIZE-1:0] index_o,
   output logic             last_o
);

   localparam bit HYP = (MMODE == MMODE_HYP);
   // Hyperbolic sequences start at 1 and end at ITERS; the others run 0..ITERS-1.
   localparam logic [PSIZE-1:0] FIRST_IDX = HYP ? PSIZE'(1) : '0;
   localparam logic [PSIZE-1:0] LAST_IDX  = HYP ? PSIZE'(ITERS) : PSIZE'(ITERS - 1);

   logic [PSIZE-1:0] index_q, index_d;
   logic             rep_q, rep_d;
   logic [N_REP-1:0] rep_hit;
   logic             rep_pending;

   for (genvar gi = 0; gi < N_REP; gi++) begin : g_rep
      assign rep_hit[gi] = HYP && (REP_IDX[gi] <= ITERS) && (int'(index_q) == REP_IDX[gi]);
   end

   // A repeat index whose first pass has not yet been written back.
   assign rep_pending = (|rep_hit) && !rep_q;
   assign last_o      = (index_q == LAST_IDX) && !rep_pending;
   assign index_o     = index_q;

   always_comb begin
      index_d = index_q;
      rep_d   = rep_q;
      if (init_i) begin
         index_d = FIRST_IDX;
         rep_d   = 1'b0;
      end else if (advance_i) begin
         if (rep_pending) begin
            rep_d = 1'b1;
         end else begin
            rep_d = 1'b0;
            // Hold on the final index so the counter never runs past ITERS.
            if (!last_o) index_d = index_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         index_q <= '0;
         rep_q   <= 1'b0;
      end else begin
         index_q <= index_d;
         rep_q   <= rep_d;
      end
   end

endmodule

// File: rtl/cordic_iter_sched.sv
// Iterative CORDIC sequencer: drives one shared rotation stage set through
// all micro-rotations of a job.
//   clock, rst               : clock and synchronous active-high reset
//   start_valid/start_ready  : job request handshake (ready only in IDLE)
//   op_vector                : 0 rotation mode, 1 vectoring mode (latched at start)
//   z_sign, y_sign           : datapath sign bits used to pick the direction
//   load_en                  : datapath loads external operands
//   exec_rott                : one pulse per micro-rotation
//   I, direction             : shift index and direction for the stages
//   wb_en                    : datapath captures stage outputs into feedback registers
//   busy                     : any state but IDLE
//   done_valid/done_ready    : result handshake
module cordic_iter_sched
   import cordic_sched_pkg::*;
#(
   parameter int    DSIZE    = 16,
   parameter int    PSIZE    = 5,
   parameter int    ITERS    = 16,
   parameter string MMODE    = "0",
   parameter int    ROTT_LAT = 2
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic             op_vector,
   input  logic             z_sign,
   input  logic             y_sign,
   output logic             load_en,
   output logic             exec_rott,
   output logic [PSIZE-1:0] I,
   output logic             direction,
   output logic             wb_en,
   output logic             busy,
   output logic             done_valid,
   input  logic             done_ready
);

   if (ITERS < 1 || ITERS > (2 ** PSIZE) - 1) begin : g_bad_iters
      $error("ITERS must lie in 1 .. 2**PSIZE-1");
   end
   if (ROTT_LAT < 1) begin : g_bad_lat
      $error("ROTT_LAT must be at least 1");
   end
   if (MMODE != MMODE_CIRC && MMODE != MMODE_LIN && MMODE != MMODE_HYP) begin : g_bad_mode
      $error("MMODE must be \"1\", \"0\" or \"-1\"");
   end
   if (DSIZE < PSIZE) begin : g_bad_dsize
      $error("DSIZE must be at least PSIZE");
   end

   localparam int            CW       = $clog2(ROTT_LAT) + 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(ROTT_LAT - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          opv_q, opv_d;
   logic          dir_q, dir_d;
   logic          dir_now;
   logic          iter_last;

   // Rotation mode steers Z towards zero, vectoring mode steers Y towards zero.
   assign dir_now = opv_q ? y_sign : ~z_sign;

   cordic_iter_index #(
      .MMODE (MMODE),
      .PSIZE (PSIZE),
      .ITERS (ITERS)
   ) u_index (
      .clock     (clock),
      .rst       (rst),
      .init_i    (load_en),
      .advance_i (wb_en),
      .index_o   (I),
      .last_o    (iter_last)
   );

   always_ff @(posedge clock) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         opv_q   <= 1'b0;
         dir_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         opv_q   <= opv_d;
         dir_q   <= dir_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      opv_d   = opv_q;
      dir_d   = dir_q;
      case (state_q)
         ST_IDLE: begin
            if (start_valid) begin
               opv_d   = op_vector;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD:  state_d = ST_ISSUE;
         ST_ISSUE: begin
            cnt_d   = CNT_INIT;
            dir_d   = dir_now;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q == '0) state_d = iter_last ? ST_DONE : ST_ISSUE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         ST_DONE: begin
            if (done_ready) state_d = ST_IDLE;
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      start_ready = (state_q == ST_IDLE);
      load_en     = (state_q == ST_LOAD);
      exec_rott   = (state_q == ST_ISSUE);
      // A reset landing on the final WAIT cycle must not commit a write-back.
      wb_en       = (state_q == ST_WAIT) && (cnt_q == '0) && !rst;
      busy        = (state_q != ST_IDLE);
      done_valid  = (state_q == ST_DONE);
      // Direction is live during ISSUE and held from the register afterwards.
      direction   = (state_q == ST_ISSUE) ? dir_now : dir_q;
   end

endmodule

// File: doc/cordic_iter_sched.md
Name: cordic_iter_sched

Overview:
Iterative CORDIC sequencer that time-multiplexes a single rotation_X / rotation_Y / rotation_Z stage set over ITERS micro-rotations.
- Accepts a job via valid/ready and loads operands into the datapath.
- Issues one exec_rott pulse per micro-rotation with shift index I and direction.
- Waits out the stage pipeline latency, then writes results back into the feedback registers.
- Signals completion via valid/ready.
- Handles circular, linear and hyperbolic (MMODE) index sequences, including the hyperbolic repeat iterations.

Parameters:
- DSIZE, 16, datapath width; used only for the status width check.
- PSIZE, 5, width of the shift index I; ITERS must not exceed 2^PSIZE-1.
- ITERS, 16, number of distinct shift indices per job.
- MMODE, "0", "1" circular, "0" linear, "-1" hyperbolic; same encoding as the rotation stages.
- ROTT_LAT, 2, cycles from exec_rott to valid stage outputs (Dyin register plus rotation register).

Ports:
- clock  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start_valid  in  1  job request.
- start_ready  out  1  high only in IDLE.
- op_vector  in  1  sampled at start accept; 0 = rotation mode (drive Z to 0), 1 = vectoring mode (drive Y to 0).
- z_sign  in  1  MSB of the residual Z register, from the datapath.
- y_sign  in  1  MSB of the current Y register, from the datapath.
- load_en  out  1  one-cycle pulse; datapath captures external Xin/Yin/Zin.
- exec_rott  out  1  one-cycle pulse per micro-rotation; connects to master_exec_rott.
- I  out  PSIZE  shift index; held stable from ISSUE through the end of WAIT.
- direction  out  1  rotation direction; held with I.
- wb_en  out  1  one-cycle pulse; datapath captures stage outputs into the feedback registers.
- busy  out  1  high in every state except IDLE.
- done_valid  out  1  result available in the datapath output registers.
- done_ready  in  1  consumer accepts the result.

Behaviour:
- Reset: state=IDLE. All outputs 0 except start_ready=1. iter index, repeat flag and wait counter cleared. Reset in any state aborts the job in the next cycle with no wb_en, and no done_valid is ever produced for it.
- States: IDLE, LOAD, ISSUE, WAIT, DONE.
- IDLE: start_ready=1. When start_valid=1, latch op_vector, go to LOAD. Start is ignored outside IDLE.
- LOAD: load_en=1 for one cycle. Initialise the index: 0 for MMODE "1" and "0", 1 for MMODE "-1". Go to ISSUE.
- ISSUE: exec_rott=1 for one cycle. I = current index.
  - Rotation mode: direction = ~z_sign.
  - Vectoring mode: direction = y_sign.
  - direction is registered at ISSUE and held until the next ISSUE.
  - Load the wait counter with ROTT_LAT-1. Go to WAIT.
- WAIT: counter decrements each cycle. When the counter reaches 0, assert wb_en that cycle and advance the index.
  - Hyperbolic only: index 4, 13 and 40 (those ≤ ITERS) are executed twice. The first pass sets the repeat flag and the index does not advance; the second pass clears the flag and the index advances.
  - Last micro-rotation: circular/linear index == ITERS-1; hyperbolic index == ITERS with no pending repeat. After its wb_en, go to DONE; otherwise go to ISSUE.
- DONE: done_valid=1, held until done_ready=1, then go to IDLE. done_valid is dropped in the cycle after the handshake. A simultaneous start_valid in that handshake cycle is not accepted; it is accepted one cycle later in IDLE.
- Sign inputs are sampled only in ISSUE, at which point the datapath feedback registers already hold the previous wb_en result.
- Execution counts:
  - N_exec = ITERS for MMODE "1" and "0".
  - N_exec = ITERS plus the number of repeat indices ≤ ITERS for MMODE "-1".
- Latency: start accept at cycle 0, LOAD at 1, first ISSUE at 2. Each micro-rotation takes ROTT_LAT+1 cycles. done_valid rises at cycle 2 + N_exec*(ROTT_LAT+1).
- Width rules:
  - Index counter is PSIZE bits and never wraps, by the ITERS ≤ 2^PSIZE-1 constraint.
  - Wait counter is clog2(ROTT_LAT)+1 bits.
  - ROTT_LAT=1 gives a single-cycle WAIT with immediate wb_en.
- Elaboration error if ITERS > 2^PSIZE-1, ROTT_LAT < 1, or MMODE is not one of the three legal strings.

Decomposition:
- Package cordic_sched_pkg holds:
  - state encoding
  - MMODE string constants
  - hyperbolic repeat-index constants (4, 13, 40)
  - the N_exec computation function
- One sub-module, cordic_iter_index: index register, repeat flag, last-iteration flag. Inputs: init, advance. Parameters: MMODE, PSIZE, ITERS.
- The FSM and wait counter stay in cordic_iter_sched.

Test Plan:
1. Circular, ITERS=16, ROTT_LAT=2, op_vector=0, start at cycle 0 → load_en at cycle 1; exec_rott at cycles 2, 5, …, 47 with I=0..15; wb_en at cycles 4, 7, …, 49; done_valid at cycle 50.
2. Hyperbolic, ITERS=16 → I sequence 1,2,3,4,4,5,…,13,13,14,15,16; 18 exec_rott pulses; done_valid at cycle 56.
3. Vectoring mode: y_sign forced 1,0,1,0… at each ISSUE → direction follows y_sign per pulse and stays constant between pulses. Rotation mode with z_sign=0 → direction=1.
4. done_ready held low for 10 cycles → done_valid stays 1, start_ready stays 0, and a start_valid pulse in that window is ignored. done_ready=1 → IDLE next cycle; back-to-back start accepted the cycle after.
5. rst asserted during WAIT of iteration 7 → next cycle state=IDLE, exec_rott/wb_en/done_valid=0, start_ready=1. A new job then completes with the full 50-cycle timing.
6. ROTT_LAT=1, linear, ITERS=4 → exec_rott at cycles 2, 4, 6, 8; wb_en at cycles 3, 5, 7, 9; done_valid at cycle 10.
